// File: rtl/uart_pkg.sv
// Shared UART constants, FSM state encoding and baud divider helper.
// Used by both the receiver and the transmitter.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_state_e;

  // Clock cycles per oversample tick, truncated.
  function automatic int unsigned uart_div(input int unsigned clk_freq,
                                           input int unsigned baud_rate);
    return clk_freq / (baud_rate * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: free-running divider with synchronous clear.
// tick_o is high for one cycle whenever the divider count equals DIV-1.
module uart_baud_tick #(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // tick_q mirrors (cnt_q == LAST) one register stage early, so it lines up with cnt_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 16x oversampling, mid-bit sampling, glitch rejection,
// framing-error and overrun detection, one-entry valid/ready holding register.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 5_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int unsigned DIV = uart_div(CLK_FREQ, BAUD_RATE);
  localparam int unsigned OSW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam logic [OSW-1:0] OS_MID  = OSW'(OVERSAMPLE / 2 - 1);
  localparam logic [OSW-1:0] OS_LAST = OSW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_BITS - 1);

  if (DIV < 1) begin : g_bad_div
    $error("uart_rx_core: CLK_FREQ too low for BAUD_RATE (DIV < 1)");
  end

  logic [1:0]           sync_q;
  logic                 rxs;
  logic                 start_det;
  logic                 tick;
  uart_state_e          state_q, state_d;
  logic [OSW-1:0]       os_q, os_d;
  logic [BCW-1:0]       bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 busy_q, busy_d;

  assign rxs       = sync_q[1];
  assign start_det = (state_q == IDLE) && !rxs;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .clr_i  (start_det),
    .tick_o (tick)
  );

  // Next-state, shift register and holding-register logic.
  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q && !rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rxs) begin
          state_d = START;
          os_d    = '0;
          bit_d   = '0;
        end
      end
      START: begin
        if (tick) begin
          if (os_q == OS_MID) begin
            os_d    = '0;
            state_d = rxs ? IDLE : DATA;
          end else begin
            os_d = os_q + OSW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          os_d = os_q + OSW'(1);
          if (os_q == OS_LAST) begin
            shift_d = {rxs, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + BCW'(1);
            if (bit_q == BIT_LAST) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          os_d = os_q + OSW'(1);
          if (os_q == OS_LAST) begin
            if (rxs) begin
              state_d = IDLE;
              if (!valid_q || rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
              end else begin
                ovr_d = 1'b1;
              end
            end else begin
              ferr_d  = 1'b1;
              state_d = BREAK;
            end
          end
        end
      end
      BREAK: begin
        // A line held low must go high before another start is accepted.
        if (rxs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= 2'b11;
      state_q <= IDLE;
      os_q    <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], UART_RX};
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_valid  = valid_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at DIV=1 (one bit = 16 clk cycles).
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_uart_rx_core;

  logic       clk = 1'b0;
  logic       reset;
  logic       UART_RX;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         rise_cyc[$];
  logic [7:0] rise_data[$];
  int         ferr_cyc[$];
  int         ovr_cyc[$];
  int         valid_cycles = 0;
  logic       prev_valid   = 1'b0;

  uart_rx_core #(.CLK_FREQ(1_600_000), .BAUD_RATE(100_000)) dut (
    .clk       (clk),
    .reset     (reset),
    .UART_RX   (UART_RX),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder: rising edges of rx_valid and the one-cycle pulses.
  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      rise_cyc.push_back(cyc);
      rise_data.push_back(rx_data);
    end
    if (rx_valid) valid_cycles <= valid_cycles + 1;
    if (frame_err) ferr_cyc.push_back(cyc);
    if (overrun) ovr_cyc.push_back(cyc);
    prev_valid <= rx_valid;
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int extra_low,
                            output int c0);
    c0 = cyc;
    UART_RX = 1'b0;
    wait_cyc(16);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      wait_cyc(16);
    end
    UART_RX = stop;
    wait_cyc(16);
    if (extra_low > 0) begin
      UART_RX = 1'b0;
      wait_cyc(extra_low);
    end
    UART_RX = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_data"}, int'(rx_data), 0);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_frame_err"}, int'(frame_err), 0);
    check({tag, "_overrun"}, int'(overrun), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_rise;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int c0, c1, r0, f0, o0, v0;

    vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
    vecs[1] = '{data: 8'h00, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
    vecs[3] = '{data: 8'h81, stop: 1'b1, exp_rise: 1, exp_ferr: 0};
    vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_rise: 0, exp_ferr: 1};

    reset    = 1'b0;
    UART_RX  = 1'b1;
    rx_ready = 1'b1;
    wait_cyc(3);
    check_reset_outputs("por");
    reset = 1'b1;
    wait_cyc(5);

    // Single frames with the consumer always ready.
    for (int i = 0; i < 5; i++) begin
      r0 = rise_cyc.size(); f0 = ferr_cyc.size(); o0 = ovr_cyc.size(); v0 = valid_cycles;
      send_frame(vecs[i].data, vecs[i].stop, 0, c0);
      wait_cyc(20);
      check($sformatf("v%0d_rise_cnt", i), rise_cyc.size() - r0, vecs[i].exp_rise);
      check($sformatf("v%0d_valid_cycles", i), valid_cycles - v0, vecs[i].exp_rise);
      check($sformatf("v%0d_ferr_cnt", i), ferr_cyc.size() - f0, vecs[i].exp_ferr);
      check($sformatf("v%0d_ovr_cnt", i), ovr_cyc.size() - o0, 0);
      if (vecs[i].exp_rise == 1 && rise_cyc.size() > r0) begin
        check($sformatf("v%0d_rise_latency", i), rise_cyc[r0] - c0, 155);
        check($sformatf("v%0d_data", i), int'(rise_data[r0]), int'(vecs[i].data));
      end
      if (vecs[i].exp_ferr == 1 && ferr_cyc.size() > f0) begin
        check($sformatf("v%0d_ferr_latency", i), ferr_cyc[f0] - c0, 155);
      end
      check($sformatf("v%0d_busy_idle", i), int'(busy), 0);
    end

    // Short start glitch is rejected at the mid-start sample.
    r0 = rise_cyc.size(); f0 = ferr_cyc.size();
    UART_RX = 1'b0;
    wait_cyc(4);
    UART_RX = 1'b1;
    check("glitch_busy_c4", int'(busy), 1);
    wait_cyc(8);
    check("glitch_busy_c12", int'(busy), 0);
    wait_cyc(200);
    check("glitch_rise_cnt", rise_cyc.size() - r0, 0);
    check("glitch_ferr_cnt", ferr_cyc.size() - f0, 0);

    // Framing error followed by a held-low line.
    r0 = rise_cyc.size(); f0 = ferr_cyc.size();
    send_frame(8'h3C, 1'b0, 40, c0);
    check("brk_busy_while_low", int'(busy), 1);
    wait_cyc(10);
    check("brk_busy_after_high", int'(busy), 0);
    wait_cyc(200);
    check("brk_rise_cnt", rise_cyc.size() - r0, 0);
    check("brk_ferr_cnt", ferr_cyc.size() - f0, 1);
    if (ferr_cyc.size() > f0) check("brk_ferr_latency", ferr_cyc[f0] - c0, 155);

    // Back-to-back frames at full line rate.
    r0 = rise_cyc.size();
    send_frame(8'h00, 1'b1, 0, c0);
    send_frame(8'hFF, 1'b1, 0, c1);
    wait_cyc(20);
    check("b2b_rise_cnt", rise_cyc.size() - r0, 2);
    if (rise_cyc.size() >= r0 + 2) begin
      check("b2b_first_latency", rise_cyc[r0] - c0, 155);
      check("b2b_spacing", rise_cyc[r0+1] - rise_cyc[r0], 160);
      check("b2b_data0", int'(rise_data[r0]), 8'h00);
      check("b2b_data1", int'(rise_data[r0+1]), 8'hFF);
    end

    // Overrun: second byte dropped while the first is still held.
    rx_ready = 1'b0;
    r0 = rise_cyc.size(); o0 = ovr_cyc.size(); f0 = ferr_cyc.size();
    send_frame(8'h11, 1'b1, 0, c0);
    send_frame(8'h22, 1'b1, 0, c1);
    wait_cyc(20);
    check("ovr_rise_cnt", rise_cyc.size() - r0, 1);
    check("ovr_cnt", ovr_cyc.size() - o0, 1);
    if (ovr_cyc.size() > o0) check("ovr_latency", ovr_cyc[o0] - c1, 155);
    check("ovr_ferr_cnt", ferr_cyc.size() - f0, 0);
    check("ovr_valid_held", int'(rx_valid), 1);
    check("ovr_data_held", int'(rx_data), 8'h11);
    rx_ready = 1'b1;
    check("ovr_read_data", int'(rx_data), 8'h11);
    wait_cyc(1);
    check("ovr_valid_cleared", int'(rx_valid), 0);

    // Reset in the middle of bit 4 aborts the frame.
    r0 = rise_cyc.size(); f0 = ferr_cyc.size();
    UART_RX = 1'b0;
    wait_cyc(16);
    UART_RX = 1'b1;
    wait_cyc(64 + 8);
    check("rst_busy_before", int'(busy), 1);
    reset = 1'b0;
    wait_cyc(2);
    check_reset_outputs("mid");
    reset = 1'b1;
    wait_cyc(72 + 20);
    check("rst_rise_cnt", rise_cyc.size() - r0, 0);
    check("rst_ferr_cnt", ferr_cyc.size() - f0, 0);
    check("rst_busy_after", int'(busy), 0);
    r0 = rise_cyc.size();
    send_frame(8'h5A, 1'b1, 0, c0);
    wait_cyc(20);
    check("post_rst_rise_cnt", rise_cyc.size() - r0, 1);
    if (rise_cyc.size() > r0) begin
      check("post_rst_latency", rise_cyc[r0] - c0, 155);
      check("post_rst_data", int'(rise_data[r0]), 8'h5A);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
